wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, meaning max consecutive ALU wins while LSU is pending; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 alu_valid  input  1  ALU writeback request this cycle.
REQ-005 alu_rd  input  5  ALU destination register index.
REQ-006 alu_data  input  32  ALU result.
REQ-007 alu_ready  output  1  ALU request is accepted this cycle if alu_valid.
REQ-008 lsu_valid  input  1  load-return writeback request.
REQ-009 lsu_rd  input  5  load destination register index.
REQ-010 lsu_data  input  32  load data.
REQ-011 lsu_ready  output  1  LSU FIFO can accept this cycle.
REQ-012 rf_write_enable  output  1  register-file write enable, registered.
REQ-013 rf_rd  output  5  register-file write index, registered.
REQ-014 rf_rd_data  output  32  register-file write data, registered.
REQ-015 lsu_fifo_count  output  2  current LSU FIFO occupancy, 0..2.

Function
REQ-016 LSU requests enter a 2-entry in-order FIFO; push when lsu_valid && lsu_ready.
REQ-017 lsu_ready = (lsu_fifo_count < 2), from registered state only; same-cycle pop does not raise lsu_ready.
REQ-018 ALU path is unbuffered; ALU accepted iff alu_valid && alu_ready.
REQ-019 Candidates each cycle: ALU (alu_valid), LSU (FIFO head, count > 0 at cycle start); an entry pushed this cycle is not eligible until the next cycle.
REQ-020 Exactly one candidate: it wins.
REQ-021 Both candidates: ALU wins unless starve_cnt == STARVE_LIMIT, in which case the LSU head wins.
REQ-022 alu_ready = !(count > 0 && starve_cnt == STARVE_LIMIT); independent of alu_valid.
REQ-023 starve_cnt (4-bit): +1 when both candidates and ALU wins; cleared when LSU wins or count == 0; never exceeds STARVE_LIMIT.
REQ-024 LSU win pops the FIFO head; simultaneous push and pop leaves count unchanged and preserves FIFO order.
REQ-025 Grant latency 1 cycle: on the edge after a win, rf_write_enable = 1, rf_rd/rf_rd_data = winner's rd/data.
REQ-026 Winner with rd == 0: request consumed (ALU accepted, or FIFO popped), rf_write_enable = 0 next cycle.
REQ-027 No winner: rf_write_enable = 0 next cycle; rf_rd and rf_rd_data hold their previous values.
REQ-028 Minimum LSU latency, push to rf_write_enable: 2 cycles; ALU: 1 cycle.
REQ-029 No ordering is enforced between ALU and LSU writes to the same rd; upstream guarantees no such overlap.
REQ-030 lsu_valid while lsu_ready == 0: request is not taken; the LSU holds it stable until accepted.

Reset
REQ-031 reset_n low asynchronously forces: count = 0, FIFO entries invalid, starve_cnt = 0, rf_write_enable = 0, rf_rd = 0, rf_rd_data = 0.
REQ-032 During reset: lsu_ready = 1, alu_ready = 1; no request is accepted.
REQ-033 Reset mid-operation discards FIFO contents and any unissued grant; the first grant after release is decided by normal arbitration.

Verification
REQ-034 ALU only: alu_valid=1, rd=5, data=0xDEADBEEF for 1 cycle -> next cycle rf_write_enable=1, rf_rd=5, rf_rd_data=0xDEADBEEF; then rf_write_enable=0.
REQ-035 LSU only: push rd=7, data=0x12345678 into empty FIFO -> count=1 next cycle -> write of rd=7 one cycle later -> count=0.
REQ-036 Starvation, STARVE_LIMIT=3: LSU entry pending, alu_valid held high with rd=1..4 -> writes rd=1,2,3; alu_ready=0 on 4th cycle; LSU rd written; ALU rd=4 written next.
REQ-037 FIFO full: 3 consecutive LSU pushes with alu_valid=1 blocking -> lsu_ready=0 when count=2; third request is held; FIFO drains in push order.
REQ-038 rd=0: ALU rd=0, data=0xFFFFFFFF -> alu_ready=1, rf_write_enable stays 0, rf_rd_data unchanged.
REQ-039 Reset mid-run: count=2, starve_cnt=2, reset_n pulsed low -> all outputs/state at reset values immediately; no stale LSU writes after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: unbuffered ALU port versus a 2-entry LSU FIFO,
// ALU-priority with a starvation bound that forces the LSU head through.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  output logic        rf_write_enable,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_rd_data,
  output logic [1:0]  lsu_fifo_count
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic [4:0]  ent_rd_q   [2];
  logic [4:0]  ent_rd_d   [2];
  logic [31:0] ent_data_q [2];
  logic [31:0] ent_data_d [2];
  logic [3:0]  starve_q, starve_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_data_q, rf_data_d;

  logic        lsu_cand, at_limit, push, alu_win, lsu_win, wr_idx;
  logic [4:0]  win_rd;
  logic [31:0] win_data;

  always_comb begin
    lsu_cand  = (count_q != 2'd0);
    at_limit  = (starve_q == LIMIT);
    alu_ready = !(lsu_cand && at_limit);
    lsu_ready = (count_q < 2'd2);
    push      = lsu_valid && lsu_ready;
    alu_win   = alu_valid && alu_ready;
    // LSU wins whenever it has a head and the ALU did not take the slot.
    lsu_win   = lsu_cand && !alu_win;
    win_rd    = alu_win ? alu_rd   : ent_rd_q[head_q];
    win_data  = alu_win ? alu_data : ent_data_q[head_q];
    // Tail slot: head when empty, the other slot when one entry is held.
    wr_idx    = head_q ^ count_q[0];

    count_d    = count_q;
    head_d     = head_q;
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    starve_d   = starve_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_data_d  = rf_data_q;

    if (push) begin
      ent_rd_d[wr_idx]   = lsu_rd;
      ent_data_d[wr_idx] = lsu_data;
    end
    if (lsu_win) head_d = ~head_q;
    count_d = count_q + {1'b0, push} - {1'b0, lsu_win};

    if (!lsu_cand || lsu_win) starve_d = '0;
    else if (alu_win)         starve_d = starve_q + 4'd1;

    if ((alu_win || lsu_win) && (win_rd != 5'd0)) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = win_rd;
      rf_data_d = win_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      head_q    <= 1'b0;
      starve_q  <= '0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        ent_rd_q[i]   <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_data_q  <= rf_data_d;
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
    end
  end

  assign rf_write_enable = rf_we_q;
  assign rf_rd           = rf_rd_q;
  assign rf_rd_data      = rf_data_q;
  assign lsu_fifo_count  = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios then random traffic, checked against a
// queue-based reference model of the arbitration rules.
module tb_wb_arbiter;

  localparam int LIMIT = 3;

  logic        clk, reset_n;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, rf_rd;
  logic [31:0] alu_data, lsu_data, rf_rd_data;
  logic        rf_write_enable;
  logic [1:0]  lsu_fifo_count;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_write_enable(rf_write_enable), .rf_rd(rf_rd), .rf_rd_data(rf_rd_data),
    .lsu_fifo_count(lsu_fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model
  wb_t         q[$];
  int          m_starve;
  logic        exp_we;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;

  // pending requests (held stable until accepted)
  logic        alu_pend, lsu_pend, alu_keep;
  logic [4:0]  alu_p_rd, lsu_p_rd;
  logic [31:0] alu_p_data, lsu_p_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_starve = 0;
    exp_we   = 1'b0;
    exp_rd   = '0;
    exp_data = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},    {31'd0, rf_write_enable}, 32'd0);
    chk({tag, "_rd"},    {27'd0, rf_rd}, 32'd0);
    chk({tag, "_data"},  rf_rd_data, 32'd0);
    chk({tag, "_count"}, {30'd0, lsu_fifo_count}, 32'd0);
    chk({tag, "_lrdy"},  {31'd0, lsu_ready}, 32'd1);
    chk({tag, "_ardy"},  {31'd0, alu_ready}, 32'd1);
  endtask

  // One clock: check registered results of the previous cycle, drive, check
  // handshake outputs, then advance the model by one arbitration decision.
  task automatic tick();
    int   cnt;
    logic alu_acc, lsu_acc;
    wb_t  w, e;
    @(negedge clk);
    chk("rf_we",   {31'd0, rf_write_enable}, {31'd0, exp_we});
    chk("rf_rd",   {27'd0, rf_rd}, {27'd0, exp_rd});
    chk("rf_data", rf_rd_data, exp_data);
    alu_valid = alu_pend; alu_rd = alu_p_rd; alu_data = alu_p_data;
    lsu_valid = lsu_pend; lsu_rd = lsu_p_rd; lsu_data = lsu_p_data;
    #1;
    cnt = q.size();
    chk("lsu_ready", {31'd0, lsu_ready}, (cnt < 2) ? 32'd1 : 32'd0);
    chk("alu_ready", {31'd0, alu_ready}, (cnt > 0 && m_starve == LIMIT) ? 32'd0 : 32'd1);
    chk("count",     {30'd0, lsu_fifo_count}, 32'(cnt));

    alu_acc = alu_pend && !(cnt > 0 && m_starve == LIMIT);
    lsu_acc = lsu_pend && (cnt < 2);
    exp_we = 1'b0;
    if (alu_acc || cnt > 0) begin
      if (alu_acc) begin
        w.rd = alu_p_rd; w.data = alu_p_data;
        m_starve = (cnt > 0) ? m_starve + 1 : 0;
      end else begin
        w = q.pop_front();
        m_starve = 0;
      end
      if (w.rd != 5'd0) begin
        exp_we = 1'b1; exp_rd = w.rd; exp_data = w.data;
      end
    end else begin
      m_starve = 0;
    end
    if (lsu_acc) begin
      e.rd = lsu_p_rd; e.data = lsu_p_data;
      q.push_back(e);
      lsu_pend = 1'b0;
    end
    if (alu_acc) begin
      alu_pend = alu_keep;
      alu_p_rd = 5'($urandom_range(31, 1));
      alu_p_data = $urandom;
    end
  endtask

  task automatic wait_lsu_taken(input string tag);
    for (int g = 0; g < 20 && lsu_pend; g++) tick();
    chk({tag, "_lsu_taken"}, {31'd0, lsu_pend}, 32'd0);
  endtask

  task automatic wait_alu_taken(input string tag);
    for (int g = 0; g < 20 && alu_pend; g++) tick();
    chk({tag, "_alu_taken"}, {31'd0, alu_pend}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] prev_data;
    reset_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    alu_pend = 1'b0; lsu_pend = 1'b0; alu_keep = 1'b0;
    alu_p_rd = '0; alu_p_data = '0; lsu_p_rd = '0; lsu_p_data = '0;
    model_reset();
    #1;
    chk_reset_outputs("por");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // ALU only
    alu_pend = 1'b1; alu_p_rd = 5'd5; alu_p_data = 32'hDEADBEEF;
    tick();
    @(posedge clk); #1;
    chk("alu_only_we",   {31'd0, rf_write_enable}, 32'd1);
    chk("alu_only_rd",   {27'd0, rf_rd}, 32'd5);
    chk("alu_only_data", rf_rd_data, 32'hDEADBEEF);
    repeat (2) tick();

    // LSU only
    lsu_pend = 1'b1; lsu_p_rd = 5'd7; lsu_p_data = 32'h12345678;
    tick();
    @(posedge clk); #1;
    chk("lsu_only_count", {30'd0, lsu_fifo_count}, 32'd1);
    chk("lsu_only_we0",   {31'd0, rf_write_enable}, 32'd0);
    tick();
    @(posedge clk); #1;
    chk("lsu_only_rd",   {27'd0, rf_rd}, 32'd7);
    chk("lsu_only_data", rf_rd_data, 32'h12345678);
    chk("lsu_only_cnt0", {30'd0, lsu_fifo_count}, 32'd0);
    repeat (2) tick();

    // starvation: LSU entry pending while the ALU streams rd=1..6
    lsu_pend = 1'b1; lsu_p_rd = 5'd9; lsu_p_data = 32'hCAFE0009;
    for (int i = 1; i <= 6; i++) begin
      alu_pend = 1'b1; alu_p_rd = 5'(i); alu_p_data = 32'(i) * 32'h1111;
      wait_alu_taken("starve");
    end
    repeat (3) tick();

    // FIFO full: continuous ALU traffic, three LSU pushes in a row
    alu_keep = 1'b1; alu_pend = 1'b1; alu_p_rd = 5'd20; alu_p_data = 32'hA0A0A0A0;
    for (int k = 0; k < 3; k++) begin
      lsu_pend = 1'b1; lsu_p_rd = 5'(10 + k); lsu_p_data = 32'hB0000000 + 32'(k);
      wait_lsu_taken("full");
    end
    alu_keep = 1'b0;
    wait_alu_taken("full_drain");
    repeat (4) tick();

    // rd == 0 from the ALU consumes the request without a write
    prev_data = exp_data;
    alu_pend = 1'b1; alu_p_rd = 5'd0; alu_p_data = 32'hFFFFFFFF;
    tick();
    chk("rd0_ardy", {31'd0, alu_ready}, 32'd1);
    @(posedge clk); #1;
    chk("rd0_we",   {31'd0, rf_write_enable}, 32'd0);
    chk("rd0_data", rf_rd_data, prev_data);
    repeat (2) tick();

    // reset mid-run with count=2, starve=2
    alu_keep = 1'b1; alu_pend = 1'b1; alu_p_rd = 5'd3; alu_p_data = 32'h33333333;
    lsu_pend = 1'b1; lsu_p_rd = 5'd12; lsu_p_data = 32'hC0000001;
    tick();
    lsu_pend = 1'b1; lsu_p_rd = 5'd13; lsu_p_data = 32'hC0000002;
    tick();
    tick();
    @(posedge clk); #1;
    chk("mid_count", {30'd0, lsu_fifo_count}, 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    chk_reset_outputs("mid_rst_hold");
    @(negedge clk);
    alu_keep = 1'b0; alu_pend = 1'b0; lsu_pend = 1'b0;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    model_reset();
    reset_n = 1'b1;
    repeat (4) tick();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if (!alu_pend && ($urandom_range(99) < 55)) begin
        alu_pend = 1'b1; alu_p_rd = 5'($urandom_range(31)); alu_p_data = $urandom;
      end
      if (!lsu_pend && ($urandom_range(99) < 50)) begin
        lsu_pend = 1'b1; lsu_p_rd = 5'($urandom_range(31)); lsu_p_data = $urandom;
      end
      tick();
    end
    alu_pend = 1'b0; lsu_pend = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
